// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
//
// Contents:
//   DIGITS_DEF - default number of multiplexed digits
//   HEX_SEG    - 16-entry nibble -> segment table, active-high, {g,f,e,d,c,b,a}
//   segPol     - converts an active-high pattern to the pin polarity
package seg_pkg;

   localparam int DIGITS_DEF = 4;

   // Entry 15 is listed first so that HEX_SEG[n] is the glyph for nibble n.
   // Glyphs A,b,C,d,E,F for 10..15.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Active-high pattern in, pin-level pattern out.
   function automatic logic [6:0] segPol(input logic [6:0] segHi, input logic activeLow);
      return segHi ^ {7{activeLow}};
   endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between a display host and the seven-segment scanner.
// Latency: none (wires only).
// Backpressure: Load is a request; LoadAck confirms it reached the display.
//
// Signals:
//   DataIn/DpIn/Load - host -> scanner: new display contents and capture request
//   LoadAck          - scanner -> host: captured data is now the displayed data
//   An/Seg/Dp        - scanner -> pins: anode select, segments, decimal point
//   FrameDone        - scanner -> host: pulse on each wrap to digit 0
interface seg_scan_if import seg_pkg::*; #(
   parameter int DIGITS = DIGITS_DEF
) ();

   logic [4*DIGITS-1:0] DataIn;
   logic [DIGITS-1:0]   DpIn;
   logic                Load;
   logic                LoadAck;
   logic [DIGITS-1:0]   An;
   logic [6:0]          Seg;
   logic                Dp;
   logic                FrameDone;

   modport master (
      output DataIn, DpIn, Load,
      input  LoadAck, An, Seg, Dp, FrameDone
   );

   modport slave (
      input  DataIn, DpIn, Load,
      output LoadAck, An, Seg, Dp, FrameDone
   );

endinterface

// File: rtl/seg_hex_decode.sv
// Nibble to seven-segment pattern decoder, active-high, {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   Nib   in  4  hex value 0..F
//   SegHi out 7  segment pattern, 1 = segment lit
module seg_hex_decode import seg_pkg::*; (
   input  logic [3:0] Nib,
   output logic [6:0] SegHi
);

   assign SegHi = HEX_SEG[Nib];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner driven by a divided scan-rate strobe.
// Latency: 3 ClkIn cycles from Tick first sampled high to the new digit on the pins.
// Backpressure: Load may be issued any time; only the last one before a frame
//               boundary is shown, and LoadAck marks when it takes effect.
//
// Ports:
//   ClkIn - system clock      rst  - synchronous active-high reset
//   Tick  - divided clock, treated as asynchronous data and edge-detected
//   bus   - slave side of seg_scan_if (load handshake and display pins)
module seg_scan import seg_pkg::*; #(
   parameter int DIGITS         = DIGITS_DEF,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int BLANK_LEAD     = 1
) (
   input  logic      ClkIn,
   input  logic      rst,
   input  logic      Tick,
   seg_scan_if.slave bus
);

   localparam int   IW       = $clog2(DIGITS);
   localparam logic ACT_LOW  = (SEG_ACTIVE_LOW != 0);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
   localparam logic [6:0]    SEG_OFF  = segPol(7'h00, ACT_LOW);
   localparam logic          DP_OFF   = ACT_LOW;

   // Tick synchroniser, edge detector and registered edge strobe
   logic tickSync1, tickSync2, tickPrev, edgeStb;

   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] dispDat, pendDat;
   logic [DIGITS-1:0]   dispDp, pendDp;
   logic                pendVld;

   logic [DIGITS-1:0]   anReg;
   logic [6:0]          segReg;
   logic                dpReg, loadAckReg, frameDoneReg;

   // Next-state values
   logic                wrap, boundary;
   logic [IW-1:0]       idxNext;
   logic [4*DIGITS-1:0] dispNextDat;
   logic [DIGITS-1:0]   dispNextDp;
   logic [3:0]          nibNext;
   logic                dpBitNext;
   logic [DIGITS-1:0]   zeroFrom;
   logic                zeroAcc;
   logic                blankNext;
   logic [6:0]          segHiNext;
   logic [6:0]          segNext;

   assign wrap     = (idx == LAST_IDX);
   assign boundary = edgeStb & wrap;
   assign idxNext  = wrap ? '0 : idx + IW'(1);

   // A Load landing on the boundary cycle goes straight to the display and
   // supersedes anything pending, so the first digit of the frame is fresh.
   always_comb begin
      dispNextDat = dispDat;
      dispNextDp  = dispDp;
      if (boundary && bus.Load) begin
         dispNextDat = bus.DataIn;
         dispNextDp  = bus.DpIn;
      end else if (boundary && pendVld) begin
         dispNextDat = pendDat;
         dispNextDp  = pendDp;
      end
   end

   // zeroFrom[i]: nibbles i..DIGITS-1 are all zero (leading-zero run)
   always_comb begin
      zeroAcc  = 1'b1;
      zeroFrom = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zeroAcc     = zeroAcc & (dispNextDat[4*i +: 4] == 4'h0);
         zeroFrom[i] = zeroAcc;
      end
   end

   always_comb begin
      nibNext   = 4'h0;
      dpBitNext = 1'b0;
      blankNext = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idxNext == IW'(i)) begin
            nibNext   = dispNextDat[4*i +: 4];
            dpBitNext = dispNextDp[i];
            blankNext = (BLANK_LEAD != 0) && (i != 0) && zeroFrom[i];
         end
      end
   end

   seg_hex_decode uDecode (
      .Nib   (nibNext),
      .SegHi (segHiNext)
   );

   assign segNext = blankNext ? SEG_OFF : segPol(segHiNext, ACT_LOW);

   always_ff @(posedge ClkIn) begin
      if (rst) begin
         tickSync1    <= 1'b0;
         tickSync2    <= 1'b0;
         tickPrev     <= 1'b0;
         edgeStb      <= 1'b0;
         idx          <= LAST_IDX;
         dispDat      <= '0;
         dispDp       <= '0;
         pendDat      <= '0;
         pendDp       <= '0;
         pendVld      <= 1'b0;
         anReg        <= '1;
         segReg       <= SEG_OFF;
         dpReg        <= DP_OFF;
         loadAckReg   <= 1'b0;
         frameDoneReg <= 1'b0;
      end else begin
         tickSync1    <= Tick;
         tickSync2    <= tickSync1;
         tickPrev     <= tickSync2;
         edgeStb      <= tickSync2 & ~tickPrev;
         loadAckReg   <= boundary & (bus.Load | pendVld);
         frameDoneReg <= boundary;
         dispDat      <= dispNextDat;
         dispDp       <= dispNextDp;

         if (boundary) begin
            pendVld <= 1'b0;
         end else if (bus.Load) begin
            pendDat <= bus.DataIn;
            pendDp  <= bus.DpIn;
            pendVld <= 1'b1;
         end

         if (edgeStb) begin
            idx    <= idxNext;
            anReg  <= ~(DIGITS'(1) << idxNext);
            segReg <= segNext;
            dpReg  <= dpBitNext ^ ACT_LOW;
         end
      end
   end

   assign bus.An        = anReg;
   assign bus.Seg       = segReg;
   assign bus.Dp        = dpReg;
   assign bus.LoadAck   = loadAckReg;
   assign bus.FrameDone = frameDoneReg;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: two instances share stimulus, one with leading
// blanking and one without; all segment values are active-low glyphs.
module tb_seg_scan;

   logic        ClkIn = 1'b0;
   logic        rst   = 1'b1;
   logic        Tick  = 1'b0;
   logic [15:0] loadDat = '0;
   logic [3:0]  loadDp  = '0;
   logic        loadReq = 1'b0;

   int nCmp   = 0;
   int nErr   = 0;
   int ackCnt = 0;
   int ackRef;
   logic monOn = 1'b0;

   always #5 ClkIn = ~ClkIn;

   seg_scan_if #(.DIGITS(4)) busA ();
   seg_scan_if #(.DIGITS(4)) busB ();

   assign busA.DataIn = loadDat;
   assign busA.DpIn   = loadDp;
   assign busA.Load   = loadReq;
   assign busB.DataIn = loadDat;
   assign busB.DpIn   = loadDp;
   assign busB.Load   = loadReq;

   seg_scan #(.DIGITS(4), .SEG_ACTIVE_LOW(1), .BLANK_LEAD(1)) dut (
      .ClkIn (ClkIn),
      .rst   (rst),
      .Tick  (Tick),
      .bus   (busA)
   );

   seg_scan #(.DIGITS(4), .SEG_ACTIVE_LOW(1), .BLANK_LEAD(0)) dutNb (
      .ClkIn (ClkIn),
      .rst   (rst),
      .Tick  (Tick),
      .bus   (busB)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns 1 ns after the n-th rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge ClkIn);
      #1;
   endtask

   // Low for 3 samples, then high; returns just after the edge where the
   // next digit reaches the pins (3 edges after Tick is first sampled high).
   task automatic tick();
      Tick = 1'b0;
      cyc(3);
      Tick = 1'b1;
      cyc(4);
   endtask

   task automatic loadOne(input logic [15:0] dat, input logic [3:0] dp);
      loadDat = dat;
      loadDp  = dp;
      loadReq = 1'b1;
      cyc(1);
      loadReq = 1'b0;
   endtask

   always @(negedge ClkIn) begin
      if (busA.LoadAck === 1'b1) ackCnt++;
      if (monOn)
         checkVal("anOneHot",
                  {31'b0, (busA.An == 4'hF) || ($countones(~busA.An) == 1)}, 32'd1);
   end

   initial begin
      // Reset state
      cyc(3);
      checkVal("rstAn", busA.An, 4'hF);
      checkVal("rstSeg", busA.Seg, 7'h7F);
      checkVal("rstDp", busA.Dp, 1'b1);
      checkVal("rstAck", busA.LoadAck, 1'b0);
      checkVal("rstFd", busA.FrameDone, 1'b0);
      rst = 1'b0;
      monOn = 1'b1;
      cyc(2);

      // First Tick: 3-cycle latency, frame boundary, digit 0 = "0"
      Tick = 1'b1;
      cyc(1);
      checkVal("latK0", busA.An, 4'hF);
      cyc(1);
      checkVal("latK1", busA.An, 4'hF);
      cyc(1);
      checkVal("latK2", busA.An, 4'hF);
      cyc(1);
      checkVal("firstAn", busA.An, 4'hE);
      checkVal("firstFd", busA.FrameDone, 1'b1);
      checkVal("firstSeg", busA.Seg, 7'h40);
      checkVal("firstDp", busA.Dp, 1'b1);
      checkVal("firstAck", busA.LoadAck, 1'b0);
      cyc(1);
      checkVal("fdPulse", busA.FrameDone, 1'b0);

      // Mid-frame load of 12AF: old (zero) data until the wrap
      loadOne(16'h12AF, 4'b0100);
      tick();
      checkVal("midAn1", busA.An, 4'hD);
      checkVal("midSeg1", busA.Seg, 7'h7F);
      checkVal("midSeg1Nb", busB.Seg, 7'h40);
      checkVal("midAck1", busA.LoadAck, 1'b0);
      tick();
      checkVal("midAn2", busA.An, 4'hB);
      checkVal("midAck2", busA.LoadAck, 1'b0);
      tick();
      checkVal("midAn3", busA.An, 4'h7);
      checkVal("midAck3", busA.LoadAck, 1'b0);
      tick();
      checkVal("wrapAck", busA.LoadAck, 1'b1);
      checkVal("wrapFd", busA.FrameDone, 1'b1);
      checkVal("wrapAn", busA.An, 4'hE);
      checkVal("digF", busA.Seg, 7'h0E);
      checkVal("dpOff0", busA.Dp, 1'b1);
      cyc(1);
      checkVal("ackPulse", busA.LoadAck, 1'b0);
      tick();
      checkVal("digA", busA.Seg, 7'h08);
      checkVal("dpOff1", busA.Dp, 1'b1);
      tick();
      checkVal("an2", busA.An, 4'hB);
      checkVal("dig2", busA.Seg, 7'h24);
      checkVal("dpOn2", busA.Dp, 1'b0);
      tick();
      checkVal("dig1", busA.Seg, 7'h79);
      checkVal("dig1Nb", busB.Seg, 7'h79);
      checkVal("dpOff3", busA.Dp, 1'b1);

      // 0007: leading blanking vs. no blanking
      loadOne(16'h0007, 4'b0000);
      tick();
      checkVal("sevenAck", busA.LoadAck, 1'b1);
      checkVal("seven", busA.Seg, 7'h78);
      checkVal("sevenNb", busB.Seg, 7'h78);
      for (int d = 1; d < 4; d++) begin
         tick();
         checkVal($sformatf("blank%0d", d), busA.Seg, 7'h7F);
         checkVal($sformatf("zeroNb%0d", d), busB.Seg, 7'h40);
      end

      // Two loads before a wrap: last wins, one ack
      ackRef = ackCnt;
      loadOne(16'h1111, 4'b0000);
      loadOne(16'h2222, 4'b0000);
      tick();
      checkVal("dblAck", busA.LoadAck, 1'b1);
      checkVal("dblSeg0", busA.Seg, 7'h24);
      tick();
      checkVal("dblSeg1", busA.Seg, 7'h24);
      tick();
      tick();
      checkVal("dblAckCnt", ackCnt - ackRef, 32'd1);

      // Load in the exact wrap cycle, with an older pending value to discard
      loadOne(16'h3333, 4'b0000);
      ackRef = ackCnt;
      Tick = 1'b0;
      cyc(3);
      Tick = 1'b1;
      cyc(3);
      loadDat = 16'h00C5;
      loadDp  = 4'b0001;
      loadReq = 1'b1;
      cyc(1);
      loadReq = 1'b0;
      checkVal("bypAck", busA.LoadAck, 1'b1);
      checkVal("bypAn", busA.An, 4'hE);
      checkVal("bypSeg", busA.Seg, 7'h12);
      checkVal("bypDp", busA.Dp, 1'b0);
      tick();
      checkVal("bypSegC", busA.Seg, 7'h46);
      checkVal("bypAckCnt", ackCnt - ackRef, 32'd1);

      // Reset at digit 1 with a pending load
      checkVal("preRstAn", busA.An, 4'hD);
      loadOne(16'h4444, 4'b1111);
      ackRef = ackCnt;
      Tick = 1'b0;
      rst  = 1'b1;
      cyc(1);
      checkVal("midRstAn", busA.An, 4'hF);
      checkVal("midRstSeg", busA.Seg, 7'h7F);
      checkVal("midRstDp", busA.Dp, 1'b1);
      checkVal("midRstAck", busA.LoadAck, 1'b0);
      checkVal("midRstFd", busA.FrameDone, 1'b0);
      cyc(1);
      rst = 1'b0;
      tick();
      checkVal("postRstAn", busA.An, 4'hE);
      checkVal("postRstSeg", busA.Seg, 7'h40);
      checkVal("postRstFd", busA.FrameDone, 1'b1);
      checkVal("postRstAck", busA.LoadAck, 1'b0);
      cyc(2);
      checkVal("postRstAckCnt", ackCnt - ackRef, 32'd0);

      // Runt Tick pulses: the monitor keeps checking An stays legal
      for (int i = 0; i < 8; i++) begin
         Tick = 1'b1;
         cyc(1 + (i % 2));
         Tick = 1'b0;
         cyc(1 + (i % 3));
      end
      cyc(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
